load_cmd_queue: RTL and testbench

Upstream command stage for the loadable up-counter. It accepts load values through a valid/ready handshake and buffers them in a small FIFO. It then issues them to the counter as single-cycle `load_o` / `load_val_o` commands. Commands are spaced by a programmable minimum gap and can optionally be aligned to the counter's wrap point using `count_i` fed back from the counter.

---
 rtl/load_cmd_queue.sv | 131 +++++++++++++
 tb/tb_load_cmd_queue.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_cmd_queue.sv
// load_cmd_queue: buffers counter load values in a small FIFO and
// issues them as spaced, optionally wrap-aligned one-cycle strobes.
module load_cmd_queue #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4,
   parameter int GAP    = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid_i,
   input  logic [DATA_W-1:0]      in_data_i,
   output logic                   in_ready_o,
   input  logic                   sync_i,
   input  logic [DATA_W-1:0]      count_i,
   output logic                   load_o,
   output logic [DATA_W-1:0]      load_val_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);
   localparam logic [7:0] GAP_LD =
      (GAP > 0) ? 8'(GAP - 1) : 8'd0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q;
   logic [PW-1:0]     rd_ptr_q;
   logic [LW-1:0]     level_q;
   logic [7:0]        gap_q;
   logic [DATA_W-1:0] val_q;
   logic              push;
   logic              pop;
   logic              start;
   logic              ready;

   // Acceptance depends on occupancy only, so a full FIFO
   // refuses data even when the same edge pops.
   assign ready      = (level_q != FULL);
   assign push       = in_valid_i && ready;
   assign start      = (state_q == S_IDLE) && (state_d == S_ISSUE);
   assign in_ready_o = ready;
   assign level_o    = level_q;
   assign load_val_o = val_q;

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state: issue only from IDLE, with an optional wrap-aligned start.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (level_q != '0 && (!sync_i || (&count_i)))
               state_d = S_ISSUE;
         end
         S_ISSUE: state_d = (GAP > 0) ? S_GAP : S_IDLE;
         S_GAP: begin
            if (gap_q == '0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from the state register alone, so the strobe is glitch-free.
   always_comb begin
      load_o = 1'b0;
      pop    = 1'b0;
      unique case (state_q)
         S_ISSUE: begin
            load_o = 1'b1;
            pop    = 1'b1;
         end
         default: begin
            load_o = 1'b0;
            pop    = 1'b0;
         end
      endcase
   end

   // Gap counter: loaded on leaving ISSUE, counts down to zero inside GAP.
   always_ff @(posedge clk) begin
      if (!reset) begin
         gap_q <= '0;
      end else if (state_q == S_ISSUE) begin
         gap_q <= GAP_LD;
      end else if (state_q == S_GAP && gap_q != '0) begin
         gap_q <= gap_q - 8'd1;
      end
   end

   // FIFO storage; contents need no reset, the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data_i;
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         unique case ({push, pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Load value captures the FIFO head as the FSM commits to an issue.
   always_ff @(posedge clk) begin
      if (!reset)     val_q <= '0;
      else if (start) val_q <= mem_q[rd_ptr_q];
   end

endmodule

// File: tb/tb_load_cmd_queue.sv
// tb_load_cmd_queue: directed bench with a timing-rule reference model,
// lane 0 uses GAP=10, lane 1 uses GAP=0.
module tb_load_cmd_queue;

   localparam int DW    = 4;
   localparam int DEPTH = 4;
   localparam int LW    = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_on = 1'b0;

   logic          rst_n [2];
   logic          vin   [2];
   logic [DW-1:0] din   [2];
   logic          syn   [2];
   logic [DW-1:0] cnt   [2];
   logic          rdy   [2];
   logic          ld    [2];
   logic [DW-1:0] ldv   [2];
   logic [LW-1:0] lvl   [2];

   int vals0  [$];
   int edges0 [$];
   int vals1  [$];
   int edges1 [$];

   always @(posedge clk) cyc <= cyc + 1;

   // Counter being driven: free-running, loaded by the strobe.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n[i])  cnt[i] <= '0;
         else if (ld[i]) cnt[i] <= ldv[i];
         else            cnt[i] <= cnt[i] + 4'd1;
      end
   end

   // Log of issued loads with the cycle they were seen in.
   always @(negedge clk) begin
      if (ld[0]) begin
         vals0.push_back(int'(ldv[0]));
         edges0.push_back(cyc);
      end
      if (ld[1]) begin
         vals1.push_back(int'(ldv[1]));
         edges1.push_back(cyc);
      end
   end

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int GP = (g == 0) ? 10 : 0;
      logic [DW-1:0] q [$];
      int            edge_n  = 0;
      int            next_ok = 0;
      logic          e_load  = 1'b0;
      logic [DW-1:0] e_val   = '0;

      load_cmd_queue #(
         .DATA_W(DW),
         .DEPTH (DEPTH),
         .GAP   (GP)
      ) dut (
         .clk       (clk),
         .reset     (rst_n[g]),
         .in_valid_i(vin[g]),
         .in_data_i (din[g]),
         .in_ready_o(rdy[g]),
         .sync_i    (syn[g]),
         .count_i   (cnt[g]),
         .load_o    (ld[g]),
         .load_val_o(ldv[g]),
         .level_o   (lvl[g])
      );

      // Reference: a load may start GP+2 edges after the previous one,
      // the entry leaves the queue one edge after its load starts.
      always @(posedge clk) begin
         bit            fire;
         bit            take;
         logic [DW-1:0] head;
         edge_n = edge_n + 1;
         if (!rst_n[g]) begin
            q.delete();
            e_load  = 1'b0;
            e_val   = '0;
            next_ok = 0;
         end else begin
            head = (q.size() > 0) ? q[0] : '0;
            take = vin[g] && (q.size() != DEPTH);
            fire = (edge_n >= next_ok) && (q.size() > 0) &&
                   (!syn[g] || cnt[g] == 4'hF);
            if (e_load) void'(q.pop_front());
            if (take) q.push_back(din[g]);
            e_load = fire;
            if (fire) begin
               e_val   = head;
               next_ok = edge_n + GP + 2;
            end
         end
      end

      // Cycle compare against the reference.
      always @(negedge clk) begin
         if (chk_on) begin
            checks++;
            if (ld[g] !== e_load || ldv[g] !== e_val ||
                lvl[g] !== LW'(q.size()) ||
                rdy[g] !== (q.size() != DEPTH)) begin
               errors++;
               $display("FAIL cycle_check lane%0d t=%0t: load=%b val=%0d level=%0d ready=%b, expected load=%b val=%0d level=%0d ready=%b",
                        g, $time, ld[g], ldv[g], lvl[g], rdy[g],
                        e_load, e_val, q.size(), (q.size() != DEPTH));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_eq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Offer v until accepted; waited counts edges refused by ready.
   task automatic push(input int i, input logic [DW-1:0] v,
                       output int waited);
      bit acc;
      waited = 0;
      vin[i] = 1'b1;
      din[i] = v;
      forever begin
         acc = rdy[i];
         @(negedge clk);
         if (acc) break;
         waited++;
         if (waited > 60) begin
            checks++;
            errors++;
            $display("FAIL push_timeout lane%0d: value %0d never accepted", i, v);
            break;
         end
      end
      vin[i] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   initial begin
      int            w;
      int            n;
      int            n0;
      logic [DW-1:0] prev;
      int            exp_a [7] = '{9, 3, 7, 12, 5, 8, 1};
      int            exp_b [10];

      for (int i = 0; i < 2; i++) begin
         rst_n[i] = 1'b0;
         vin[i]   = 1'b1;
         din[i]   = 4'hA;
         syn[i]   = 1'b0;
      end
      tick(1);
      chk_on = 1'b1;
      tick(2);
      expect_eq("reset_level", int'(lvl[0]), 0);
      expect_eq("reset_load", int'(ld[0]), 0);
      expect_eq("reset_val", int'(ldv[0]), 0);
      expect_eq("reset_ready", int'(rdy[0]), 1);
      expect_eq("reset_level_gap0", int'(lvl[1]), 0);
      for (int i = 0; i < 2; i++) begin
         rst_n[i] = 1'b1;
         vin[i]   = 1'b0;
      end
      tick(1);

      push(0, 4'd9, w);
      expect_eq("single_level_push", int'(lvl[0]), 1);
      expect_eq("single_load_early", int'(ld[0]), 0);
      tick(1);
      expect_eq("single_load", int'(ld[0]), 1);
      expect_eq("single_val", int'(ldv[0]), 9);
      tick(1);
      expect_eq("single_load_off", int'(ld[0]), 0);
      expect_eq("single_level_pop", int'(lvl[0]), 0);
      expect_eq("single_val_hold", int'(ldv[0]), 9);
      tick(12);

      push(0, 4'd3, w);
      push(0, 4'd7, w);
      push(0, 4'd12, w);
      push(0, 4'd5, w);
      push(0, 4'd8, w);
      expect_eq("b2b_level_full", int'(lvl[0]), 4);
      expect_eq("b2b_ready_full", int'(rdy[0]), 0);
      push(0, 4'd1, w);
      expect_eq("b2b_stall_cycles", w, 10);
      n = 0;
      while (vals0.size() < 7 && n < 100) begin
         tick(1);
         n++;
      end
      tick(1);
      expect_eq("b2b_load_count", vals0.size(), 7);
      for (int i = 0; i < 7; i++)
         if (i < vals0.size())
            expect_eq($sformatf("b2b_val%0d", i), vals0[i], exp_a[i]);
      for (int i = 2; i < 7; i++)
         if (i < edges0.size())
            expect_eq($sformatf("b2b_spacing%0d", i),
                      edges0[i] - edges0[i-1], 12);
      tick(12);

      rst_n[0] = 1'b0;
      tick(1);
      rst_n[0] = 1'b1;
      syn[0]   = 1'b1;
      push(0, 4'd6, w);
      n    = 0;
      prev = cnt[0];
      while (!ld[0] && n < 40) begin
         prev = cnt[0];
         tick(1);
         n++;
      end
      expect_eq("sync_wait", n, 15);
      expect_eq("sync_count_seen", int'(prev), 15);
      expect_eq("sync_val", int'(ldv[0]), 6);
      tick(1);
      expect_eq("sync_count_loaded", int'(cnt[0]), 6);
      syn[0] = 1'b0;
      tick(12);

      for (int i = 0; i < 10; i++) begin
         exp_b[i] = (i * 3 + 1) % 16;
         push(1, DW'(exp_b[i]), w);
      end
      n = 0;
      while (vals1.size() < 10 && n < 80) begin
         tick(1);
         n++;
      end
      tick(1);
      expect_eq("gap0_load_count", vals1.size(), 10);
      for (int i = 0; i < 10; i++)
         if (i < vals1.size())
            expect_eq($sformatf("gap0_val%0d", i), vals1[i], exp_b[i]);
      for (int i = 1; i < 10; i++)
         if (i < edges1.size())
            expect_eq($sformatf("gap0_spacing%0d", i),
                      edges1[i] - edges1[i-1], 2);
      expect_eq("gap0_level_end", int'(lvl[1]), 0);

      push(0, 4'd4, w);
      push(0, 4'd5, w);
      push(0, 4'd6, w);
      tick(3);
      expect_eq("mid_level", int'(lvl[0]), 2);
      n0 = vals0.size();
      rst_n[0] = 1'b0;
      tick(1);
      rst_n[0] = 1'b1;
      expect_eq("mid_reset_load", int'(ld[0]), 0);
      expect_eq("mid_reset_level", int'(lvl[0]), 0);
      tick(30);
      expect_eq("mid_no_more_loads", vals0.size(), n0);
      if (n0 > 0)
         expect_eq("mid_last_val", vals0[n0-1], 4);
      push(0, 4'd2, w);
      expect_eq("post_load_early", int'(ld[0]), 0);
      tick(1);
      expect_eq("post_load", int'(ld[0]), 1);
      expect_eq("post_val", int'(ldv[0]), 2);
      tick(14);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
